stage_elastic: RTL
==================

Name: stage_elastic

Overview:
- Parametrised successor to the fixed stage-2 pipeline register.
- Carries opcode, soft-error flag, parity-checked host data (DPP: data plus parity) and network data-plus-tag (NDT) between pipeline stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush and a saturating soft-error counter.
- Sits between the parity/tag-check front end and the RX/TX mux; downstream can stall without data loss.

Parameters:
- DATA_SIZE, 32, data payload width in bits.
- TAG_SIZE, 8, network tag width in bits.
- OPCODE_W, 2, opcode width in bits.
- ERR_CNT_W, 8, soft-error counter width in bits.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents a transaction.
- in_ready  out  1  stage can accept a transaction.
- opcode_in  in  OPCODE_W  opcode.
- soft_error_in  in  1  soft-error flag.
- dpp_in  in  DATA_SIZE+1  data plus parity; parity is bit 0.
- ndt_in  in  DATA_SIZE+TAG_SIZE  network data plus tag; tag is in the low TAG_SIZE bits.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- opcode_out  out  OPCODE_W  head opcode.
- soft_error_out  out  1  head soft-error flag.
- dpp_out  out  DATA_SIZE+1  head DPP.
- ndt_out  out  DATA_SIZE+TAG_SIZE  head NDT.
- tx_data  out  DATA_SIZE  equals dpp_out[DATA_SIZE:1].
- rx_data  out  DATA_SIZE  equals ndt_out[DATA_SIZE+TAG_SIZE-1:TAG_SIZE].
- rx_tag  out  TAG_SIZE  equals ndt_out[TAG_SIZE-1:0].
- flush  in  1  synchronous discard of all entries.
- err_clear  in  1  synchronous clear of err_count.
- err_count  out  ERR_CNT_W  saturating count of accepted transactions with soft_error_in=1.
- occupancy  out  2  number of valid entries: 0, 1 or 2.

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers clear: main, skid, err_count and valids;
  - out_valid=0, in_ready=1, occupancy=0, all payload outputs 0.
- Handshake definitions:
  - push = in_valid & in_ready;
  - pop = out_valid & out_ready.
- Signals change only on clk rising edges; in_ready is registered.
- in_ready = !skid_valid, driven from a register, not combinationally from out_ready.
- Storage:
  - main register drives all *_out ports;
  - skid register holds an overflow entry;
  - order is strictly FIFO.
- State machine, encoded by occupancy:
  - EMPTY: push -> ONE (main<=in).
  - ONE:
    - push & !pop -> FULL (skid<=in);
    - pop & !push -> EMPTY;
    - push & pop -> ONE (main<=in).
  - FULL (in_ready=0):
    - pop -> ONE (main<=skid);
    - otherwise hold.
- Latency: a push at edge k appears on outputs after edge k when the stage is empty.
- Payload stability: while out_valid=1 and out_ready=0, all *_out ports are stable.
- Non-valid data: when out_valid=0, payload outputs hold their last value.
- Flush:
  - has priority over push and pop in the same cycle;
  - the next state is EMPTY and the main payload registers are zeroed;
  - in_ready returns to 1 on the next cycle;
  - a transaction presented with flush is dropped and not counted.
- err_count:
  - increments on push with soft_error_in=1;
  - saturates at 2^ERR_CNT_W-1 with no wrap;
  - err_clear wins over a simultaneous increment;
  - flush does not affect err_count.
- rx_data, rx_tag and tx_data are purely combinational slices of the output registers.

Test Plan:
- Reset mid-stream: assert reset=0 asynchronously while FULL -> immediately out_valid=0, occupancy=0, in_ready=1, dpp_out=0, err_count=0.
- Pass-through with out_ready=1: push dpp_in=0x1_2345_6789 (DATA_SIZE=32) and ndt_in=0xAABBCCDD_5A -> next cycle out_valid=1, tx_data=0x91A2B3C4, rx_data=0xAABBCCDD, rx_tag=0x5A; streaming B2B gives one transaction per cycle.
- Backpressure: out_ready=0, push A then B -> occupancy=2, in_ready=0, C is held off. Then out_ready=1 -> outputs A then B in order, with in_ready=1 one cycle after the first pop.
- Simultaneous push/pop in ONE: occupancy stays 1 and the head updates to the new entry each cycle.
- Flush in FULL together with in_valid=1 -> next cycle occupancy=0, out_valid=0 and the new entry is dropped; err_count is unchanged.
- Error counter with ERR_CNT_W=2: push 5 transactions with soft_error_in=1 -> err_count=3 (saturated). Then err_clear with a simultaneous error push -> err_count=0.

Source files
------------

// File: rtl/stage_elastic.sv
// stage_elastic: elastic pipeline stage between the parity/tag-check front end
// and the RX/TX mux. Carries opcode, soft-error flag, DPP (data plus parity,
// parity in bit 0) and NDT (network data plus tag, tag in the low bits).
// A 2-entry skid buffer lets downstream stall without losing data, and the
// accepted-ready path never depends combinationally on out_ready.
//
// Ports:
//   clk, reset (async active-low)
//   in_valid / in_ready          upstream handshake (in_ready registered)
//   opcode_in, soft_error_in, dpp_in, ndt_in   upstream payload
//   out_valid / out_ready        downstream handshake
//   opcode_out, soft_error_out, dpp_out, ndt_out  head-entry payload
//   tx_data, rx_data, rx_tag     combinational slices of the head payload
//   flush                        synchronous discard of all entries
//   err_clear, err_count         saturating soft-error counter
//   occupancy                    number of valid entries (0..2)
module stage_elastic #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TAG_SIZE  = 8,
    parameter int unsigned OPCODE_W  = 2,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OPCODE_W-1:0]           opcode_in,
    input  logic                          soft_error_in,
    input  logic [DATA_SIZE:0]            dpp_in,
    input  logic [DATA_SIZE+TAG_SIZE-1:0] ndt_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OPCODE_W-1:0]           opcode_out,
    output logic                          soft_error_out,
    output logic [DATA_SIZE:0]            dpp_out,
    output logic [DATA_SIZE+TAG_SIZE-1:0] ndt_out,
    output logic [DATA_SIZE-1:0]          tx_data,
    output logic [DATA_SIZE-1:0]          rx_data,
    output logic [TAG_SIZE-1:0]           rx_tag,
    input  logic                          flush,
    input  logic                          err_clear,
    output logic [ERR_CNT_W-1:0]          err_count,
    output logic [1:0]                    occupancy
);

    localparam int unsigned DPP_W = DATA_SIZE + 1;
    localparam int unsigned NDT_W = DATA_SIZE + TAG_SIZE;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic                soft_error;
        logic [DPP_W-1:0]    dpp;
        logic [NDT_W-1:0]    ndt;
    } entry_t;

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    entry_t                main_q, main_d;
    entry_t                skid_q, skid_d;
    entry_t                in_entry;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [ERR_CNT_W-1:0]  err_q, err_d;
    logic                  push;
    logic                  pop;

    assign in_entry = '{opcode: opcode_in, soft_error: soft_error_in,
                        dpp: dpp_in, ndt: ndt_in};

    // Next-state, storage steering and error counter.
    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        err_d    = err_q;
        push     = in_valid & in_ready_q;
        pop      = out_valid_q & out_ready;

        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_d  = in_entry;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_entry;
                    end else if (push) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can move us.
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // A transaction presented alongside flush is dropped, so not counted.
        if (err_clear) begin
            err_d = '0;
        end else if (push && soft_error_in && !flush && (err_q != '1)) begin
            err_d = err_q + ERR_CNT_W'(1);
        end

        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // State, storage and handshake registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            err_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign occupancy      = state_q;
    assign err_count      = err_q;
    assign opcode_out     = main_q.opcode;
    assign soft_error_out = main_q.soft_error;
    assign dpp_out        = main_q.dpp;
    assign ndt_out        = main_q.ndt;
    assign tx_data        = main_q.dpp[DATA_SIZE:1];
    assign rx_data        = main_q.ndt[NDT_W-1:TAG_SIZE];
    assign rx_tag         = main_q.ndt[TAG_SIZE-1:0];

endmodule
